fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of storage entries (>=2, not necessarily a power of two).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port push_i, input, 1, write request for data_i this cycle.
REQ-006 The block SHALL have port pop_i, input, 1, read request; removes the head entry this cycle.
REQ-007 The block SHALL have port data_i, input, WIDTH, write data.
REQ-008 The block SHALL have port data_o, output, WIDTH, head-of-queue data (first-word-fall-through).
REQ-009 The block SHALL have port full_o, output, 1, high when occupancy == DEPTH.
REQ-010 The block SHALL have port empty_o, output, 1, high when occupancy == 0.
REQ-011 The block SHALL have port nearly_full_o, output, 1, high when occupancy == DEPTH-1.
REQ-012 The block SHALL have port nearly_empty_o, output, 1, high when occupancy == 1.

Function
REQ-013 The block SHALL keep a storage array of DEPTH x WIDTH, a write pointer, a read pointer and an occupancy count of width clog2(DEPTH+1).
REQ-014 The block SHALL accept a push (write data_i at write pointer, advance write pointer, count+1) when push_i=1 and full_o=0.
REQ-015 The block SHALL accept a pop (advance read pointer, count-1) when pop_i=1 and empty_o=0.
REQ-016 The block SHALL ignore push_i while full_o=1, even if pop_i=1 in the same cycle; no data or pointer change from the push.
REQ-017 The block SHALL ignore pop_i while empty_o=1, even if push_i=1 in the same cycle; the push still proceeds.
REQ-018 The block SHALL, on simultaneous accepted push and pop, perform both and leave count unchanged.
REQ-019 The block SHALL wrap each pointer from DEPTH-1 to 0 on advance, for any DEPTH value.
REQ-020 The block SHALL drive data_o combinationally from the storage entry at the read pointer, so a pushed word appears on data_o the cycle after its push when it is the head.
REQ-021 The block SHALL, after a pop, present the next entry on data_o in the following cycle (zero-latency FWFT).
REQ-022 The block SHALL derive full_o, empty_o, nearly_full_o, nearly_empty_o combinationally from the registered count only; flags change one cycle after the causing push/pop edge.
REQ-023 The block SHALL preserve FIFO order: words pop in exactly the order accepted.
REQ-024 The block SHALL leave data_o showing the stale entry at the read pointer while empty; its value is not meaningful then.

Reset
REQ-025 The block SHALL, while rst_i=1, immediately clear pointers, count and all storage entries to 0, independent of clk_i.
REQ-026 The block SHALL present after reset: empty_o=1, full_o=0, nearly_full_o=0, nearly_empty_o=0, data_o=0.
REQ-027 The block SHALL discard all contents when reset asserts mid-operation, and ignore push_i/pop_i while rst_i=1.

Verification
REQ-028 Reset then idle -> empty_o=1, full_o=0, nearly_empty_o=0, nearly_full_o=0, data_o=0.
REQ-029 DEPTH=4: push 0x11,0x22,0x33,0x44 on consecutive cycles -> nearly_empty_o after 1st, nearly_full_o after 3rd, full_o after 4th; data_o=0x11 throughout.
REQ-030 From full, push 0x55 -> ignored; pop 4 times -> data_o shows 0x11,0x22,0x33,0x44 in order, then empty_o=1.
REQ-031 Pop while empty -> count, pointers and flags unchanged; push+pop while empty -> only push, count=1, data_o=push data.
REQ-032 Occupancy 2, push+pop same cycle for 6 cycles -> count stays 2, pointers wrap, ordering intact.
REQ-033 Assert rst_i mid-stream with 3 entries, between clock edges -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy flags.
// The storage, pointers and count clear asynchronously on rst_i. DEPTH does not need to be a power of two.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             nearly_full_o,
  output logic             nearly_empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_PTR  = ptr_t'(DEPTH - 1);
  localparam cnt_t FULL_CNT  = cnt_t'(DEPTH);
  localparam cnt_t NFULL_CNT = cnt_t'(DEPTH - 1);
  localparam cnt_t ONE_CNT   = cnt_t'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             count;
  logic             do_push;
  logic             do_pop;

  // An explicit wrap lets DEPTH be any value, not only a power of two.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // NOTE: the storage is cleared on reset so that data_o reads 0 after reset.
  // Without this reset the array could map onto plain RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // The flags are decoded from the registered count only, so they change one cycle after the push or pop edge.
  assign data_o         = mem[rd_ptr];
  assign full_o         = (count == FULL_CNT);
  assign empty_o        = (count == '0);
  assign nearly_full_o  = (count == NFULL_CNT);
  assign nearly_empty_o = (count == ONE_CNT);

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: a queue model tracks the accepted words and the occupancy.
// Pops compare data_o against the queue head, and the flags are checked after every cycle.
module tb_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             full, empty, nfull, nempty;

  logic [WIDTH-1:0] sb[$];
  int               mcount = 0;
  int               tests = 0;
  int               failed = 0;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .pop_i         (pop),
    .data_i        (din),
    .data_o        (dout),
    .full_o        (full),
    .empty_o       (empty),
    .nearly_full_o (nfull),
    .nearly_empty_o(nempty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".empty"},  32'(empty),  32'(mcount == 0));
    check({tag, ".full"},   32'(full),   32'(mcount == DEPTH));
    check({tag, ".nfull"},  32'(nfull),  32'(mcount == DEPTH - 1));
    check({tag, ".nempty"}, 32'(nempty), 32'(mcount == 1));
    if (mcount > 0) check({tag, ".head"}, 32'(dout), 32'(sb[0]));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".empty"},  32'(empty),  32'd1);
    check({tag, ".full"},   32'(full),   32'd0);
    check({tag, ".nfull"},  32'(nfull),  32'd0);
    check({tag, ".nempty"}, 32'(nempty), 32'd0);
    check({tag, ".dout"},   32'(dout),   32'd0);
  endtask

  // Drives one cycle. A pop compares the current head against the scoreboard before the clock edge.
  task automatic step(input string tag, input logic p, input logic q, input logic [WIDTH-1:0] d);
    logic acc_push, acc_pop;
    @(negedge clk);
    push = p;
    pop  = q;
    din  = d;
    acc_push = p && (mcount != DEPTH);
    acc_pop  = q && (mcount != 0);
    #1;
    if (acc_pop) check({tag, ".pop_data"}, 32'(dout), 32'(sb.pop_front()));
    @(posedge clk);
    if (acc_push) sb.push_back(d);
    mcount = mcount + int'(acc_push) - int'(acc_pop);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] pushes [4];
    pushes[0] = 8'h11; pushes[1] = 8'h22; pushes[2] = 8'h33; pushes[3] = 8'h44;

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 check_reset_values("idle");

    // Fill the FIFO. The flags step through each level while 0x11 stays at the head.
    for (int i = 0; i < 4; i++) begin
      step("fill", 1'b1, 1'b0, pushes[i]);
      check("fill.head11", 32'(dout), 32'h11);
    end

    // A push while full is ignored. Draining the FIFO then returns the words in order.
    step("push_full", 1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 8'h00);

    // A pop while empty is ignored. A push and pop together while empty only pushes.
    step("pop_empty", 1'b0, 1'b1, 8'h00);
    step("pushpop_empty", 1'b1, 1'b1, 8'hA5);
    check("pushpop_empty.dout", 32'(dout), 32'hA5);
    step("to_two", 1'b1, 1'b0, 8'h5A);

    // Push and pop together at occupancy 2, over enough cycles to wrap the pointers.
    for (int i = 0; i < 6; i++) step("steady", 1'b1, 1'b1, 8'(8'hC0 + i));

    // Fill the FIFO. A push and pop together while full only pops.
    step("refill", 1'b1, 1'b0, 8'h77);
    step("refill", 1'b1, 1'b0, 8'h88);
    step("pushpop_full", 1'b1, 1'b1, 8'h99);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Assert reset between clock edges, with 3 entries stored.
    while (mcount > 3) step("trim", 1'b0, 1'b1, 8'h00);
    while (mcount < 3) step("top", 1'b1, 1'b0, 8'($urandom));
    @(posedge clk);
    #3 rst = 1'b1;
    push = 1'b1;
    pop  = 1'b1;
    #1 check_reset_values("mid_reset");
    sb.delete();
    mcount = 0;
    @(posedge clk); #1 check_reset_values("held_reset");
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk) rst = 1'b0;
    step("post_reset", 1'b1, 1'b0, 8'h3C);
    step("post_reset", 1'b0, 1'b1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
